// File: rtl/nand_gate.sv
// Buffered bitwise NAND: WIDTH independent lanes feeding a DEPTH-entry result FIFO with valid/ready handshakes.
// Optional delivered-result counter (txn_count) is built only when NAND_GATE_STATS_EN is defined.
module nand_gate #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef NAND_GATE_STATS_EN
  ,
  output logic [15:0]      txn_count
`endif
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             push_s, pop_s;
`ifdef NAND_GATE_STATS_EN
  logic [15:0]      txn_count_q, txn_count_d;
`endif

  // in_ready is forced low by reset so a push can never land in the reset cycle.
  assign in_ready  = (count_q < DEPTH_C) && !rst;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid_q && out_ready;

  // Next-state: pointers, occupancy, storage and the registered head view.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = ~(a & b);
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != {CNT_W{1'b0}});
    // Present the next head one cycle after it is written; hold y when draining to empty.
    if (out_valid_d) begin
      y_d = mem_d[rd_ptr_d];
    end else begin
      y_d = y_q;
    end
  end

`ifdef NAND_GATE_STATS_EN
  // Delivered-result counter advances on pops only and wraps naturally at 16 bits.
  always_comb begin
    if (pop_s) begin
      txn_count_d = txn_count_q + 16'd1;
    end else begin
      txn_count_d = txn_count_q;
    end
  end

  // Statistics register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_q <= 16'd0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count = txn_count_q;
`endif

  // Control state with synchronous reset; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  // Result storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate (WIDTH=8, DEPTH=2) against a queue-based reference model.
// Checks txn_count too when NAND_GATE_STATS_EN is defined.
module tb_nand_gate;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
`ifdef NAND_GATE_STATS_EN
  logic [15:0]      txn_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] ref_q [$];
  logic [WIDTH-1:0] ref_y;
  logic [15:0]      ref_txn;

  always #5 clk = ~clk;

  nand_gate #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef NAND_GATE_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] av,
                      input logic [WIDTH-1:0] bv, input logic ordy);
    logic pu;
    logic po;
    logic [WIDTH-1:0] dropped;
    @(negedge clk);
    rst = r; in_valid = iv; a = av; b = bv; out_ready = ordy;
    #1;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, (!r && (ref_q.size() < DEPTH))});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, (ref_q.size() > 0)});
    check_eq("y", {24'd0, y}, {24'd0, ref_y});
`ifdef NAND_GATE_STATS_EN
    check_eq("txn_count", {16'd0, txn_count}, {16'd0, ref_txn});
`endif
    @(posedge clk);
    if (r) begin
      ref_q.delete();
      ref_y   = 8'h00;
      ref_txn = 16'h0000;
    end else begin
      pu = iv && (ref_q.size() < DEPTH);
      po = ordy && (ref_q.size() > 0);
      if (po) begin
        dropped = ref_q.pop_front();
        ref_txn = ref_txn + 16'd1;
      end
      if (pu) ref_q.push_back(~(av & bv));
      if (ref_q.size() > 0) ref_y = ref_q[0];
    end
  endtask

  // Sample outputs shortly after the edge just taken by step().
  task automatic peek(input string tag, input logic [WIDTH-1:0] exp_y);
    #2;
    check_eq(tag, {24'd0, y}, {24'd0, exp_y});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    ref_y = 8'h00; ref_txn = 16'h0000;

    // Reset state.
    step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Truth table on all lanes, streaming with out_ready=1.
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b1); peek("tt_00", 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'hFF, 1'b1); peek("tt_01", 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1); peek("tt_10", 8'hFF);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1); peek("tt_11", 8'h00);
    step(1'b0, 1'b1, 8'h0A, 8'h0C, 1'b1); peek("tt_lanes", 8'hF7);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Wide lanes into an empty buffer.
    step(1'b0, 1'b1, 8'hF0, 8'hCC, 1'b0); peek("wide_3f", 8'h3F);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Backpressure: fill, refuse a third pair, then drain in order.
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    #2 check_eq("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step(1'b0, 1'b1, 8'h55, 8'h55, 1'b0); peek("bp_head", 8'hFF);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1); peek("bp_pop1", 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1); peek("bp_pop2", 8'h00);
    #1 check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Simultaneous push/pop at count=1.
    step(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    step(1'b0, 1'b1, 8'h56, 8'h78, 1'b1);
    step(1'b0, 1'b1, 8'h9A, 8'hBC, 1'b1);
    step(1'b0, 1'b1, 8'hDE, 8'hF0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset mid-operation with a full buffer.
    step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'h03, 8'h03, 1'b1);
    #2 check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_y", {24'd0, y}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'hAA, 8'h0F, 1'b0); peek("post_rst", 8'hF5);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
           WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3) != 0);
    end

`ifdef NAND_GATE_STATS_EN
    // Counter wrap: 65534 streaming pops reach 0xFFFE, two more wrap to 0x0000.
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      step(1'b0, 1'b1, WIDTH'(i), 8'h5A, 1'b1);
    end
    #2 check_eq("txn_fffe", {16'd0, txn_count}, 32'h0000FFFE);
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    #2 check_eq("txn_wrap", {16'd0, txn_count}, 32'h00000000);
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    #2 check_eq("txn_push_only", {16'd0, txn_count}, 32'h00000000);
`endif

    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nand_gate.md
NAND_GATE -- requirements
Module: nand_gate

Interface
REQ-001 Parameter WIDTH, default 1, sets the number of independent NAND bit lanes; legal range 1 to 64.
REQ-002 Parameter DEPTH, default 2, sets the number of result buffer entries; legal values are 2 and 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the operand pair on a/b is offered.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-007 Port a, input, WIDTH bits: first operand.
REQ-008 Port b, input, WIDTH bits: second operand.
REQ-009 Port out_valid, output, 1 bit: y holds a valid result.
REQ-010 Port out_ready, input, 1 bit: the consumer takes y this cycle.
REQ-011 Port y, output, WIDTH bits: the buffered result, equal to ~(a & b) bitwise.
REQ-012 Port txn_count, output, 16 bits: delivered-result counter; the port exists only when NAND_GATE_STATS_EN is defined.

Function
REQ-013 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; the block stores ~(a & b) for every bit lane independently.
REQ-014 Per-lane truth table: 0,0 gives 1; 0,1 gives 1; 1,0 gives 1; 1,1 gives 0.
REQ-015 Results SHALL be delivered in FIFO order from a DEPTH-entry buffer, with occupancy count ranging from 0 to DEPTH.
REQ-016 Latency: a result pushed at edge n SHALL appear on y with out_valid=1 in the cycle after edge n, when the buffer was empty beforehand; there is no combinational a/b-to-y path.
REQ-017 out_valid SHALL equal (count != 0), and y SHALL show the head entry; when count=0, y holds its last value.
REQ-018 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal (count < DEPTH) and rst=0; in_ready SHALL NOT depend on out_ready.
REQ-020 When full (count=DEPTH), in_valid is ignored; the producer holds its operands until in_ready=1.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged; the new entry goes behind the remaining entries.
REQ-022 A pop when count=0 SHALL be impossible, because out_valid=0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 While out_ready=0, y and out_valid SHALL stay stable.

Reset
REQ-025 When rst=1 at a rising edge: count=0, pointers=0, out_valid=0, y=0, and txn_count=0 if present.
REQ-026 While rst=1, in_ready SHALL be 0; any push or pop attempted in that cycle is discarded.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; the first post-reset push follows REQ-016.

Configuration
REQ-028 Macro NAND_GATE_STATS_EN SHALL control the statistics feature.
REQ-029 With the macro defined: txn_count increments by 1 on every pop, wraps from 0xFFFF to 0x0000, and is unaffected by pushes.
REQ-030 Without the macro: txn_count and its register are absent, and all other behaviour is identical.

Verification
REQ-031 Truth table (WIDTH=1, out_ready=1): push a,b = 00, 01, 10, 11 on consecutive cycles -> y = 1, 1, 1, 0, each one cycle after its push.
REQ-032 Backpressure (DEPTH=2): hold out_ready=0 and push 00 then 11 -> in_ready=0 after the second push and a third operand pair is not accepted; raise out_ready -> y = 1 then 0 in order, after which in_ready returns to 1.
REQ-033 Simultaneous events: with count=1 and in_valid=1, out_ready=1 for 3 cycles -> count stays 1 and results stream out in order with no loss.
REQ-034 Reset mid-operation: buffer full, assert rst for 1 cycle -> out_valid=0, y=0, in_ready=0 during reset and in_ready=1 afterwards; no stale data appears.
REQ-035 Wide lanes (WIDTH=8): a=0xF0, b=0xCC -> y=0x3F.
REQ-036 Statistics (macro defined): preload txn_count to 0xFFFE via 2 fewer than 65536 pops (or force), then 2 pops -> txn_count=0x0000.
